// File: rtl/frodo_host_bridge.sv
// rtl/frodo_host_bridge.sv - host load/run/dump command bridge around the Frodo accelerator
// Optional RUN watchdog is compiled in with FRODO_BRIDGE_TIMEOUT_EN.
module frodo_host_bridge #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic                  cmd_bank,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic [1:0]            cmd_level,
    input  logic [1:0]            cmd_mode,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [ADDR_WIDTH-1:0] mem0_addr,
    output logic [ADDR_WIDTH-1:0] mem1_addr,
    output logic                  mem0_wr_en,
    output logic                  mem1_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem0_rd_data,
    input  logic [DATA_WIDTH-1:0] mem1_rd_data,
    output logic                  acc_start,
    output logic [1:0]            acc_level,
    output logic [1:0]            acc_mode,
    input  logic                  acc_valid,
    output logic                  busy,
    output logic                  cmd_done,
    output logic                  err
);

    localparam int CW = ADDR_WIDTH + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_RUN_START = 3'd2;
    localparam logic [2:0] S_RUN_WAIT  = 3'd3;
    localparam logic [2:0] S_DUMP      = 3'd4;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_DUMP = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    logic [2:0]            state;
    logic                  bank_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CW-1:0]         len_q;
    logic [1:0]            level_q;
    logic [1:0]            mode_q;
    logic [CW-1:0]         count;
    logic                  rd_pending;
    logic                  rd_last;
    logic [DATA_WIDTH-1:0] fifo_data [0:1];
    logic                  fifo_last [0:1];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;
    logic                  cmd_done_q;
    logic                  err_q;

`ifdef FRODO_BRIDGE_TIMEOUT_EN
    logic [31:0]           timer;
`endif

    logic                  cmd_fire;
    logic                  first_issue;
    logic                  dump_issue;
    logic                  rd_issue;
    logic                  issue_last;
    logic                  pop;
    logic                  load_fire;
    logic                  run_active;
    logic [1:0]            occ_after;
    logic [ADDR_WIDTH-1:0] seq_addr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] rd_word;

    assign cmd_ready   = (state == S_IDLE) && !rst;
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign s_ready     = (state == S_LOAD);
    assign load_fire   = s_valid && s_ready;

    // The first DUMP read goes out in the accept cycle so the host sees data two cycles later.
    assign first_issue = cmd_fire && (cmd_op == OP_DUMP) && (cmd_len != '0);

    assign m_valid     = (occ != 2'd0);
    assign m_data      = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_last      = m_valid && fifo_last[rd_ptr];
    assign pop         = m_valid && m_ready;

    // Occupancy once this cycle's pop and landing read are accounted for; keeps 1 word/cycle.
    assign occ_after   = occ + {1'b0, rd_pending} - {1'b0, pop};
    assign dump_issue  = (state == S_DUMP) && (count < len_q) && (occ_after < 2'd2);
    assign rd_issue    = first_issue || dump_issue;
    assign issue_last  = first_issue ? (cmd_len == CW'(1)) : (count == len_q - CW'(1));

    assign seq_addr    = base_q + count[ADDR_WIDTH-1:0];
    assign mem_addr    = first_issue ? cmd_base :
                         ((state == S_LOAD) || (state == S_DUMP)) ? seq_addr : '0;
    assign mem0_addr   = mem_addr;
    assign mem1_addr   = mem_addr;
    assign mem0_wr_en  = load_fire && !bank_q;
    assign mem1_wr_en  = load_fire && bank_q;
    assign mem_wr_data = (state == S_LOAD) ? s_data : '0;
    assign rd_word     = bank_q ? mem1_rd_data : mem0_rd_data;

    assign run_active  = (state == S_RUN_START) || (state == S_RUN_WAIT);
    assign acc_start   = (state == S_RUN_START);
    assign acc_level   = run_active ? level_q : 2'd0;
    assign acc_mode    = run_active ? mode_q : 2'd0;

    assign busy        = (state != S_IDLE);
    assign cmd_done    = cmd_done_q;
    assign err         = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            bank_q       <= 1'b0;
            base_q       <= '0;
            len_q        <= '0;
            level_q      <= 2'd0;
            mode_q       <= 2'd0;
            count        <= '0;
            rd_pending   <= 1'b0;
            rd_last      <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            occ          <= 2'd0;
            cmd_done_q   <= 1'b0;
            err_q        <= 1'b0;
`ifdef FRODO_BRIDGE_TIMEOUT_EN
            timer        <= '0;
`endif
        end else begin
            cmd_done_q <= 1'b0;
            rd_pending <= rd_issue;
            rd_last    <= issue_last;
            occ        <= occ_after;
            if (rd_pending) begin
                fifo_data[wr_ptr] <= rd_word;
                fifo_last[wr_ptr] <= rd_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        bank_q  <= cmd_bank;
                        base_q  <= cmd_base;
                        len_q   <= cmd_len;
                        level_q <= cmd_level;
                        mode_q  <= cmd_mode;
                        err_q   <= (cmd_op == OP_RSVD);
                        count   <= first_issue ? CW'(1) : '0;
                        case (cmd_op)
                            OP_LOAD: begin
                                if (cmd_len == '0) cmd_done_q <= 1'b1;
                                else               state      <= S_LOAD;
                            end
                            OP_RUN:  state <= S_RUN_START;
                            OP_DUMP: begin
                                if (cmd_len == '0) cmd_done_q <= 1'b1;
                                else               state      <= S_DUMP;
                            end
                            default: cmd_done_q <= 1'b1;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (load_fire) begin
                        count <= count + CW'(1);
                        if (count + CW'(1) == len_q) begin
                            cmd_done_q <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                end
                S_RUN_START: begin
                    state <= S_RUN_WAIT;
`ifdef FRODO_BRIDGE_TIMEOUT_EN
                    timer <= '0;
`endif
                end
                S_RUN_WAIT: begin
                    if (acc_valid) begin
                        cmd_done_q <= 1'b1;
                        state      <= S_IDLE;
                    end
`ifdef FRODO_BRIDGE_TIMEOUT_EN
                    else if (timer == 32'(TIMEOUT_CYCLES - 1)) begin
                        err_q      <= 1'b1;
                        cmd_done_q <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
`endif
                end
                S_DUMP: begin
                    if (dump_issue) begin
                        count <= count + CW'(1);
                    end
                    if (pop && m_last) begin
                        cmd_done_q <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/frodo_host_bridge.md
Name: frodo_host_bridge

Overview:
- Host-side command/stream bridge directly upstream and downstream of the Frodo accelerator top.
- Before a run, it loads 64-bit operand words from a host stream into mem0/mem1 through one RAM port per bank.
- It pulses the accelerator start with the chosen level/mode and waits for the accelerator's valid.
- It then streams a result window from either bank back to the host with full backpressure.

Parameters:
ADDR_WIDTH, 12, word address width of each 64-bit RAM bank
DATA_WIDTH, 64, RAM/stream word width
TIMEOUT_CYCLES, 1000000, RUN watchdog limit (used only with FRODO_BRIDGE_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=LOAD, 1=RUN, 2=DUMP, 3=reserved
cmd_bank  in  1  0=mem0, 1=mem1 (LOAD/DUMP)
cmd_base  in  ADDR_WIDTH  first word address
cmd_len  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH
cmd_level  in  2  security level for RUN
cmd_mode  in  2  mode for RUN
s_data  in  DATA_WIDTH  load stream word
s_valid  in  1  load word offered
s_ready  out  1  load word accepted when valid&ready
m_data  out  DATA_WIDTH  dump stream word
m_valid  out  1  dump word offered
m_ready  in  1  host accepts dump word
m_last  out  1  final word of a DUMP
mem0_addr / mem1_addr  out  ADDR_WIDTH  bank port address
mem0_wr_en / mem1_wr_en  out  1  bank write enable
mem_wr_data  out  DATA_WIDTH  write data, shared by both banks
mem0_rd_data / mem1_rd_data  in  DATA_WIDTH  read data, 1-cycle synchronous latency
acc_start  out  1  one-cycle start pulse
acc_level  out  2  level held for the whole RUN
acc_mode  out  2  mode held for the whole RUN
acc_valid  in  1  accelerator completion
busy  out  1  state != IDLE
cmd_done  out  1  one-cycle pulse at command completion
err  out  1  sticky error flag, cleared by the next accepted command

Behaviour:
- Reset:
  - Every output is 0, including acc_level and acc_mode.
  - State returns to IDLE.
  - Counters and the output FIFO are cleared.
  - Reset mid-command aborts it with no cmd_done.
- States: IDLE, LOAD, RUN_START, RUN_WAIT, DUMP.
- IDLE:
  - cmd_ready=1.
  - On handshake, the block latches bank, base, len, level and mode, clears err, and dispatches on op.
  - op=3: err=1, cmd_done pulses the next cycle, stays IDLE.
  - len=0 for LOAD/DUMP: cmd_done the next cycle, no memory access.
- LOAD:
  - s_ready=1.
  - Each s_valid&s_ready writes s_data to the selected bank at addr=base+count in the same cycle (combinational wr_en, registered addr/data path allowed only if zero-bubble).
  - The unselected bank's wr_en stays 0.
  - Address wraps modulo 2^ADDR_WIDTH.
  - After the len-th word: s_ready drops the next cycle, cmd_done pulses, return to IDLE.
- RUN_START:
  - acc_start=1 for exactly one cycle, then go to RUN_WAIT.
  - acc_level/acc_mode are driven from the latched values from entry into RUN_START until return to IDLE.
- RUN_WAIT:
  - acc_valid is sampled starting the cycle after the start pulse.
  - First high sample: cmd_done pulses, go to IDLE.
  - acc_valid high during RUN_START is ignored.
- DUMP:
  - Reads are issued at base+issued_count.
  - A read is issued only when FIFO occupancy + in-flight reads < 2.
  - Read data enters a 2-entry FIFO one cycle later.
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - m_last=1 on the head word when it is word index len-1.
  - With m_ready held high, throughput is 1 word/cycle after a 2-cycle initial latency (cmd accept -> first m_valid).
  - m_data/m_last stay stable while m_valid&!m_ready.
  - After the last handshake: cmd_done pulses, return to IDLE.
- While not IDLE, cmd_ready=0.
- In LOAD, mem_wr_data=s_data; wr_en is never asserted in other states.
- Counters are ADDR_WIDTH+1 bits so len=2^ADDR_WIDTH is exact.

Optional Feature:
- Macro: FRODO_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter runs in RUN_WAIT.
  - If TIMEOUT_CYCLES elapse without acc_valid: err=1, cmd_done pulses, return to IDLE.
  - The counter clears on entry to RUN_START.
- Undefined: no counter logic; RUN_WAIT waits indefinitely; err is set only by op=3.

Test Plan:
1. LOAD bank0 base=0x010 len=4, words 0xA0..0xA3, with s_valid low on alternate cycles -> mem0 addrs 0x010..0x013 hold 0xA0..0xA3; mem1_wr_en never high; one cmd_done.
2. DUMP bank0 base=0x010 len=4, m_ready pattern 1,0,0,1,1,1 -> m_data 0xA0..0xA3 in order, no duplicates or drops; m_last only on 0xA3; data stable during stalls.
3. LOAD bank1 base=0xFFE len=4, then DUMP the same range with m_ready=1 -> writes to 0xFFE, 0xFFF, 0x000, 0x001; dump delivers 4 consecutive cycles after a 2-cycle latency.
4. RUN level=2 mode=1, acc_valid asserted 50 cycles after start, and acc_valid held high during the start cycle -> exactly one acc_start pulse; acc_level=2 and acc_mode=1 held; cmd_done the cycle after the first post-start acc_valid.
5. DUMP len=0 and op=3 -> cmd_done the next cycle with no reads; op=3 also sets err=1; the next valid command clears err.
6. rst asserted mid-DUMP (after 2 words) -> the next cycle all outputs are 0 and state is IDLE; with FRODO_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=100 and no acc_valid, err=1 and cmd_done fire after 100 RUN_WAIT cycles.
